clock_set_ctrl: RTL and testbench
=================================

# clock_set_ctrl

Time-set and run-control stage sitting between the 1 Hz tick generator and the seconds/tens-of-seconds counter. Debounces the four slide/push switches, runs a RUN / SET_SEC / SET_MIN mode FSM, gates the 1 Hz enable, and issues one-cycle increment/clear pulses to the counter. It also drives per-digit blank flags so the display digit being edited blinks.

## Interface
- DB_CYCLES, 1_000_000: consecutive stable cycles required before a switch change is accepted (20 ms at 50 MHz).
- BLINK_CYCLES, 12_500_000: half-period of the edit blink, in clock cycles.
- CLK  in  1  system clock.
- RST  in  1  reset; one clock, asynchronous, active-high.
- SW  in  4  raw switches: [0] mode step, [1] increment, [2] clear, [3] hold (level).
- en1hz_in  in  1  one-cycle 1 Hz tick from the tick generator.
- en1hz_out  out  1  gated tick to the counter.
- inc_sec  out  1  one-cycle pulse: advance the seconds digit by one.
- inc_min  out  1  one-cycle pulse: advance the tens digit by one.
- clr  out  1  one-cycle pulse: zero both digits.
- blank  out  2  [0] blank HEX0, [1] blank HEX1.
- mode  out  2  current FSM state: 0 RUN, 1 SET_SEC, 2 SET_MIN.

## Operation
- Each SW bit: 2-FF synchronizer, then debounce counter. While the synchronized value differs from the debounced value, the counter increments. When it reaches DB_CYCLES-1, the debounced value takes the new level and the counter clears. Any return to the debounced value clears the counter.
- Rising-edge detect on debounced SW[0..2] gives internal pulses mode_p, inc_p and clr_p. SW[3] is used as a level (hold).
- FSM: RUN -> SET_SEC -> SET_MIN -> RUN, advancing once per mode_p. Encoding 2'd3 is unreachable and, if ever entered, goes to RUN.
- en1hz_out = en1hz_in AND (state == RUN) AND NOT hold. This is combinational from registered state/hold; zero latency.
- inc_p in SET_SEC -> inc_sec; inc_p in SET_MIN -> inc_min; inc_p in RUN -> ignored.
- clr_p -> clr in any state; the state is unchanged.
- Simultaneous mode_p and inc_p: the increment targets the pre-transition state. Simultaneous clr_p and inc_p: both pulses are issued, and the counter gives clr priority.
- Blink: a counter runs 0..BLINK_CYCLES-1 and toggles phase at wrap. On entry to SET_SEC or SET_MIN, and on every inc_p, the counter and phase reset to 0 so the digit is visible.
- blank[0] = (state == SET_SEC) & phase; blank[1] = (state == SET_MIN) & phase. In RUN, blank = 2'b00.
- Reset values: state RUN, mode 0, all debounced values 0, all counters 0, phase 0. Outputs inc_sec, inc_min, clr and blank are all 0. en1hz_out follows its equation, so it passes en1hz_in immediately after reset.
- RST asserted mid-debounce or mid-blink: all progress is discarded, with no pulse on release.

## Timing
- A SW level held from edge k is synchronized at edge k+2 and accepted as debounced at edge k+1+DB_CYCLES.
- The registered pulse output (inc_sec, inc_min, clr) is high for exactly one cycle, starting at edge k+2+DB_CYCLES.
- A glitch shorter than DB_CYCLES cycles produces no pulse and no state change.
- mode updates on the same edge the corresponding pulse would appear.
- Pulses never repeat while a switch is held. The next pulse requires a debounced release and then a new press.

## Structure
- Shared package clock_pkg: mode encodings MODE_RUN / MODE_SET_SEC / MODE_SET_MIN, and switch index constants SW_MODE=0, SW_INC=1, SW_CLR=2, SW_HOLD=3.
- Sub-module sw_debounce: one bit, synchronizer plus counter, parameter DB_CYCLES, output the debounced level. Instantiated 4×.
- Counter widths are $clog2 of their parameters.

## Test plan
Bench settings are DB_CYCLES=4 and BLINK_CYCLES=8.
- Reset then RUN, en1hz_in pulsed every 10 cycles -> en1hz_out mirrors it; mode=0; blank=00; no other pulses.
- SW[0] glitch high for 2 cycles -> no mode change. SW[0] held high -> mode=1 exactly 6 edges after the first sample; en1hz_out stays 0 while en1hz_in pulses.
- In SET_SEC, press SW[1] three times (each held 6 cycles, released 6) -> exactly 3 one-cycle inc_sec, zero inc_min. blank[0] toggles every 8 cycles and restarts at 0 after each press.
- Step to SET_MIN, press SW[1] -> inc_min once. Step again -> mode=0 and blank=00. Press SW[1] in RUN -> no pulse.
- SW[3] high in RUN -> en1hz_out 0. SW[2] press in each mode -> one clr pulse per press; mode unchanged.
- RST asserted asynchronously mid-press (debounce count 3) and while in SET_MIN -> all outputs 0 and mode=0 immediately. After release, no pulse appears until a fresh press.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared definitions for the clock set/run control path: mode encodings and
// switch bit positions.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_SEC = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_e;

    localparam int NUM_SW  = 4;
    localparam int SW_MODE = 0;
    localparam int SW_INC  = 1;
    localparam int SW_CLR  = 2;
    localparam int SW_HOLD = 3;

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: 2-FF synchronizer followed by a stable-count debouncer.
module sw_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic dout
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          s1, s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            // Any return to the accepted level discards partial progress.
            if (s2 != dout) begin
                if (cnt == CW'(DB_CYCLES - 1)) begin
                    dout <= s2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set mode control for the two-digit counter: debounced switches, mode FSM,
// 1 Hz gating, increment/clear pulses and edit-digit blinking.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DB_CYCLES    = 1_000_000,
    parameter int BLINK_CYCLES = 12_500_000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] SW,
    input  logic       en1hz_in,
    output logic       en1hz_out,
    output logic       inc_sec,
    output logic       inc_min,
    output logic       clr,
    output logic [1:0] blank,
    output logic [1:0] mode
);

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    logic [NUM_SW-1:0] deb;
    logic [2:0]        deb_d;
    logic              mode_p, inc_p, clr_p, hold;
    mode_e             state, next;
    logic [BW-1:0]     blink_cnt;
    logic              phase;
    logic              blink_rst;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_db
        sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .CLK  (CLK),
            .RST  (RST),
            .din  (SW[i]),
            .dout (deb[i])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) deb_d <= '0;
        else     deb_d <= deb[2:0];
    end

    assign mode_p = deb[SW_MODE] & ~deb_d[SW_MODE];
    assign inc_p  = deb[SW_INC]  & ~deb_d[SW_INC];
    assign clr_p  = deb[SW_CLR]  & ~deb_d[SW_CLR];
    assign hold   = deb[SW_HOLD];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= MODE_RUN;
        else     state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            MODE_RUN:     if (mode_p) next = MODE_SET_SEC;
            MODE_SET_SEC: if (mode_p) next = MODE_SET_MIN;
            MODE_SET_MIN: if (mode_p) next = MODE_RUN;
            default:      next = MODE_RUN;
        endcase
    end

    // Increments target the state before any simultaneous mode step.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            inc_sec <= 1'b0;
            inc_min <= 1'b0;
            clr     <= 1'b0;
        end else begin
            inc_sec <= inc_p & (state == MODE_SET_SEC);
            inc_min <= inc_p & (state == MODE_SET_MIN);
            clr     <= clr_p;
        end
    end

    // Restarting on entry and on each increment keeps the edited digit visible.
    assign blink_rst = inc_p | ((next != state) &&
                                (next == MODE_SET_SEC || next == MODE_SET_MIN));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign en1hz_out = en1hz_in & (state == MODE_RUN) & ~hold;
    assign blank[0]  = (state == MODE_SET_SEC) & phase;
    assign blank[1]  = (state == MODE_SET_MIN) & phase;
    assign mode      = state;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce and blink periods.
module tb_clock_set_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] SW;
    logic       en1hz_in;
    logic       en1hz_out, inc_sec, inc_min, clr;
    logic [1:0] blank, mode;

    int chk = 0;
    int err = 0;
    int n_sec = 0, n_min = 0, n_clr = 0, n_dbl = 0;
    logic p_sec = 1'b0, p_min = 1'b0, p_clr = 1'b0;

    clock_set_ctrl #(.DB_CYCLES(4), .BLINK_CYCLES(8)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SW        (SW),
        .en1hz_in  (en1hz_in),
        .en1hz_out (en1hz_out),
        .inc_sec   (inc_sec),
        .inc_min   (inc_min),
        .clr       (clr),
        .blank     (blank),
        .mode      (mode)
    );

    always #5 CLK = ~CLK;

    // Pulse tally; a pulse seen on two consecutive cycles counts as a double.
    always @(negedge CLK) begin
        if (inc_sec) n_sec++;
        if (inc_min) n_min++;
        if (clr)     n_clr++;
        if ((inc_sec && p_sec) || (inc_min && p_min) || (clr && p_clr)) n_dbl++;
        p_sec = inc_sec;
        p_min = inc_min;
        p_clr = clr;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int idx, input int hold_c, input int rel_c);
        SW[idx] = 1'b1;
        tick(hold_c);
        SW[idx] = 1'b0;
        tick(rel_c);
    endtask

    task automatic tick_check(input string tag, input logic exp);
        en1hz_in = 1'b1;
        #1;
        check(tag, en1hz_out, exp);
        en1hz_in = 1'b0;
    endtask

    initial begin
        RST = 1'b1; SW = 4'b0; en1hz_in = 1'b0;
        tick(2);
        check("rst_mode", mode, 2'd0);
        check("rst_blank", blank, 2'b00);
        check("rst_pulses", {inc_sec, inc_min, clr}, 3'b000);
        tick_check("rst_en_pass", 1'b1);
        tick(1);
        RST = 1'b0;

        for (int i = 0; i < 3; i++) begin
            tick(9);
            tick_check("run_en_hi", 1'b1);
            #1;
            check("run_en_lo", en1hz_out, 1'b0);
        end
        check("run_mode", mode, 2'd0);

        // Short glitch on mode switch
        SW[0] = 1'b1; tick(2); SW[0] = 1'b0; tick(10);
        check("glitch_mode", mode, 2'd0);
        check("glitch_pulses", n_sec + n_min + n_clr, 0);

        // Real mode press with exact latency and blink phase
        SW[0] = 1'b1;
        tick(6);
        check("mode_pre", mode, 2'd0);
        tick(1);
        check("mode_step1", mode, 2'd1);
        check("ss_blank_e0", blank, 2'b00);
        tick_check("ss_en_gated", 1'b0);
        tick(7);
        check("ss_blank_e7", blank, 2'b00);
        tick(1);
        check("ss_blank_e8", blank, 2'b01);
        tick(7);
        check("ss_blank_e15", blank, 2'b01);
        tick(1);
        check("ss_blank_e16", blank, 2'b00);
        SW[0] = 1'b0;
        tick(6);

        // First increment: blink restarts on the pulse edge
        SW[1] = 1'b1;
        tick(6);
        check("inc1_pre_blank", blank, 2'b01);
        check("inc1_pre_cnt", n_sec, 0);
        tick(1);
        check("inc1_pulse", inc_sec, 1'b1);
        check("inc1_blank_rst", blank, 2'b00);
        SW[1] = 1'b0;
        tick(6);
        check("inc1_blank_p6", blank, 2'b00);
        tick(2);
        check("inc1_blank_p8", blank, 2'b01);
        press(1, 6, 6);
        press(1, 6, 6);
        check("ss_inc_sec_n", n_sec, 3);
        check("ss_inc_min_n", n_min, 0);
        check("ss_mode_kept", mode, 2'd1);

        // SET_MIN
        press(0, 6, 6);
        check("mode_step2", mode, 2'd2);
        check("sm_blank_entry", blank, 2'b00);
        press(1, 6, 6);
        check("sm_inc_min_n", n_min, 1);
        check("sm_inc_sec_n", n_sec, 3);
        check("sm_blank_p5", blank, 2'b00);
        tick(3);
        check("sm_blank_p8", blank, 2'b10);

        press(0, 6, 6);
        check("mode_step3", mode, 2'd0);
        check("run_blank", blank, 2'b00);
        press(1, 6, 6);
        check("run_inc_ign_sec", n_sec, 3);
        check("run_inc_ign_min", n_min, 1);

        // Hold gates the tick
        SW[3] = 1'b1; tick(6);
        tick_check("hold_gated", 1'b0);
        SW[3] = 1'b0; tick(6);
        tick_check("hold_released", 1'b1);

        // Clear in every mode
        press(2, 6, 6);
        check("clr_run_n", n_clr, 1);
        check("clr_run_mode", mode, 2'd0);
        press(0, 6, 6);
        press(2, 6, 6);
        check("clr_ss_n", n_clr, 2);
        check("clr_ss_mode", mode, 2'd1);
        press(0, 6, 6);
        press(2, 6, 6);
        check("clr_sm_n", n_clr, 3);
        check("clr_sm_mode", mode, 2'd2);

        // Async reset mid-debounce while in SET_MIN
        SW[1] = 1'b1;
        tick(5);
        #2;
        RST = 1'b1;
        #1;
        check("arst_mode", mode, 2'd0);
        check("arst_pulses", {inc_sec, inc_min, clr}, 3'b000);
        check("arst_blank", blank, 2'b00);
        SW = 4'b0;
        tick(2);
        RST = 1'b0;
        tick(12);
        check("post_rst_sec", n_sec, 3);
        check("post_rst_min", n_min, 1);
        check("post_rst_mode", mode, 2'd0);
        press(2, 6, 6);
        check("post_rst_clr", n_clr, 4);
        check("no_double_pulse", n_dbl, 0);

        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
